// File: rtl/rv32i_mc_ctrl_pkg.sv
// Shared types for the RV32I multi-cycle controller: FSM states, opcodes,
// PC/writeback mux encodings and the decode legality helper.
package rv32i_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;

  localparam logic [1:0] WB_ALU    = 2'd0;
  localparam logic [1:0] WB_LOAD   = 2'd1;
  localparam logic [1:0] WB_LINK   = 2'd2;
  localparam logic [1:0] WB_UPPER  = 2'd3;

  function automatic logic decode_legal(input logic [6:0] opcode, input logic [2:0] funct3);
    logic legal;
    case (opcode)
      OP_LOAD:  legal = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      OP_STORE: legal = (funct3 inside {3'b000, 3'b001, 3'b010});
      OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
      default:  legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/rv32i_mc_ctrl_if.sv
// Instruction/data memory handshake bundle between the controller and memories.
interface rv32i_mc_ctrl_if;
  logic [31:0] idata;
  logic        imem_req;
  logic        imem_ready;
  logic        dmem_req;
  logic        dmem_ready;
  logic [3:0]  we;

  modport master (output imem_req, dmem_req, we, input idata, imem_ready, dmem_ready);
  modport slave  (input imem_req, dmem_req, we, output idata, imem_ready, dmem_ready);
endinterface

// File: rtl/rv32i_mc_ctrl_store_mask.sv
// Byte-enable mask and alignment check from funct3 and the low address bits;
// shared by stores (mask) and loads (alignment only).
module rv32i_store_mask (
  input  logic [2:0] funct3,
  input  logic [1:0] daddr_lo,
  output logic [3:0] we_mask,
  output logic       misaligned
);

  // access size decode: byte, halfword (signed/unsigned), word
  always_comb begin
    we_mask    = 4'b0000;
    misaligned = 1'b0;
    case (funct3)
      3'b000, 3'b100: begin
        we_mask    = 4'b0001 << daddr_lo;
        misaligned = 1'b0;
      end
      3'b001, 3'b101: begin
        we_mask    = 4'b0011 << daddr_lo;
        misaligned = daddr_lo[0];
      end
      3'b010: begin
        we_mask    = 4'b1111;
        misaligned = (daddr_lo != 2'b00);
      end
      default: begin
        we_mask    = 4'b0000;
        misaligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle RV32I sequencing controller: FETCH/DECODE/EXEC/MEM/WB with
// memory wait states, sticky TRAP on illegal or misaligned instructions.
module rv32i_mc_ctrl
  import rv32i_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  rv32i_mc_ctrl_if.master        mem,
  input  logic [1:0]             daddr_lo,
  input  logic                   br_taken,
  output logic                   ir_we,
  output logic                   pc_we,
  output logic [1:0]             pc_sel,
  output logic [1:0]             wb_sel,
  output logic                   wer,
  output logic                   illegal,
  output logic [31:0]            instret,
  output logic [2:0]             state
);

  state_e      state_q, state_d;
  logic        illegal_q, illegal_d;
  logic [31:0] instret_q, instret_d;
  logic [6:0]  opcode_q, opcode_d;
  logic [2:0]  funct3_q, funct3_d;

  logic        imem_req_s, dmem_req_s, ir_we_s, pc_we_s, wer_s;
  logic [1:0]  pc_sel_s, wb_sel_s;
  logic [3:0]  we_s, mask_s;
  logic        misaligned_s, is_load_s, is_store_s;

  assign is_load_s  = (opcode_q == OP_LOAD);
  assign is_store_s = (opcode_q == OP_STORE);

  rv32i_store_mask u_store_mask (
    .funct3     (funct3_q),
    .daddr_lo   (daddr_lo),
    .we_mask    (mask_s),
    .misaligned (misaligned_s)
  );

  // next-state, instruction copy and per-state control outputs
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    funct3_d   = funct3_q;
    imem_req_s = 1'b0;
    dmem_req_s = 1'b0;
    ir_we_s    = 1'b0;
    pc_we_s    = 1'b0;
    wer_s      = 1'b0;
    pc_sel_s   = PC_PLUS4;
    wb_sel_s   = WB_ALU;
    we_s       = 4'b0000;
    case (state_q)
      ST_FETCH: begin
        imem_req_s = 1'b1;
        if (mem.imem_ready) begin
          ir_we_s  = 1'b1;
          opcode_d = mem.idata[6:0];
          funct3_d = mem.idata[14:12];
          state_d  = ST_DECODE;
        end else begin
          state_d  = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (decode_legal(opcode_q, funct3_q)) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_TRAP;
        end
      end
      ST_EXEC: begin
        if (opcode_q == OP_BRANCH) begin
          pc_we_s  = 1'b1;
          pc_sel_s = br_taken ? PC_BRANCH : PC_PLUS4;
          state_d  = ST_FETCH;
        end else if (is_load_s || is_store_s) begin
          state_d  = misaligned_s ? ST_TRAP : ST_MEM;
        end else begin
          state_d  = ST_WB;
        end
      end
      ST_MEM: begin
        dmem_req_s = 1'b1;
        we_s       = is_store_s ? mask_s : 4'b0000;
        if (!mem.dmem_ready) begin
          state_d = ST_MEM;
        end else if (is_store_s) begin
          pc_we_s = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        wer_s   = 1'b1;
        pc_we_s = 1'b1;
        state_d = ST_FETCH;
        case (opcode_q)
          OP_LOAD:          wb_sel_s = WB_LOAD;
          OP_JAL: begin
            wb_sel_s = WB_LINK;
            pc_sel_s = PC_BRANCH;
          end
          OP_JALR: begin
            wb_sel_s = WB_LINK;
            pc_sel_s = PC_JALR;
          end
          OP_LUI, OP_AUIPC: wb_sel_s = WB_UPPER;
          default:          wb_sel_s = WB_ALU;
        endcase
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_TRAP;
      end
    endcase
  end

  // sticky trap flag rises together with entry into TRAP
  always_comb begin
    illegal_d = illegal_q | (state_d == ST_TRAP);
    instret_d = instret_q + {31'd0, pc_we_s};
  end

  // state and counters, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
      instret_q <= 32'd0;
      opcode_q  <= 7'd0;
      funct3_q  <= 3'd0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
      opcode_q  <= opcode_d;
      funct3_q  <= funct3_d;
    end
  end

  // every output is forced low while reset is held
  always_comb begin
    if (reset) begin
      mem.imem_req = 1'b0;
      mem.dmem_req = 1'b0;
      mem.we       = 4'b0000;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = 2'd0;
      wb_sel       = 2'd0;
      wer          = 1'b0;
      illegal      = 1'b0;
      instret      = 32'd0;
      state        = 3'd0;
    end else begin
      mem.imem_req = imem_req_s;
      mem.dmem_req = dmem_req_s;
      mem.we       = we_s;
      ir_we        = ir_we_s;
      pc_we        = pc_we_s;
      pc_sel       = pc_sel_s;
      wb_sel       = wb_sel_s;
      wer          = wer_s;
      illegal      = illegal_q;
      instret      = instret_q;
      state        = state_q;
    end
  end

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// Directed self-checking bench for rv32i_mc_ctrl with hand-computed expectations.
module tb_rv32i_mc_ctrl;
  import rv32i_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic [1:0]  daddr_lo;
  logic        br_taken;
  logic        ir_we, pc_we, wer, illegal;
  logic [1:0]  pc_sel, wb_sel;
  logic [31:0] instret;
  logic [2:0]  state;

  int          checks;
  int          failures;
  logic [31:0] exp_instret;

  rv32i_mc_ctrl_if mem_if ();

  rv32i_mc_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .mem      (mem_if.master),
    .daddr_lo (daddr_lo),
    .br_taken (br_taken),
    .ir_we    (ir_we),
    .pc_we    (pc_we),
    .pc_sel   (pc_sel),
    .wb_sel   (wb_sel),
    .wer      (wer),
    .illegal  (illegal),
    .instret  (instret),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FETCH (with optional wait states) then DECODE; returns at the start of the next state
  task automatic fetch(input logic [31:0] word, input int waits);
    for (int i = 0; i < waits; i++) begin
      mem_if.imem_ready = 1'b0;
      mem_if.idata      = 32'hDEAD_BEEF;
      #2;
      chk("fetch_wait_state", 32'(state), 32'(ST_FETCH));
      chk("fetch_wait_irwe", 32'(ir_we), 32'd0);
      tick();
    end
    mem_if.imem_ready = 1'b1;
    mem_if.idata      = word;
    #2;
    chk("fetch_imem_req", 32'(mem_if.imem_req), 32'd1);
    chk("fetch_ir_we", 32'(ir_we), 32'd1);
    tick();
    mem_if.imem_ready = 1'b0;
    mem_if.idata      = 32'd0;
    #2;
    chk("decode_state", 32'(state), 32'(ST_DECODE));
    chk("decode_ir_we", 32'(ir_we), 32'd0);
    tick();
  endtask

  task automatic exec_to_wb();
    #2;
    chk("exec_state", 32'(state), 32'(ST_EXEC));
    chk("exec_pc_we", 32'(pc_we), 32'd0);
    chk("exec_wer", 32'(wer), 32'd0);
    tick();
  endtask

  task automatic wb_cycle(input logic [1:0] exp_wb, input logic [1:0] exp_pc);
    #2;
    chk("wb_state", 32'(state), 32'(ST_WB));
    chk("wb_wer", 32'(wer), 32'd1);
    chk("wb_pc_we", 32'(pc_we), 32'd1);
    chk("wb_sel", 32'(wb_sel), 32'(exp_wb));
    chk("wb_pc_sel", 32'(pc_sel), 32'(exp_pc));
    tick();
    exp_instret = exp_instret + 32'd1;
    chk("retire_instret", instret, exp_instret);
    chk("retire_state", 32'(state), 32'(ST_FETCH));
  endtask

  initial begin
    checks            = 0;
    failures          = 0;
    exp_instret       = 32'd0;
    reset             = 1'b1;
    daddr_lo          = 2'd0;
    br_taken          = 1'b0;
    mem_if.idata      = 32'd0;
    mem_if.imem_ready = 1'b0;
    mem_if.dmem_ready = 1'b0;
    tick();
    tick();
    #2;
    chk("rst_imem_req", 32'(mem_if.imem_req), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    reset = 1'b0;
    #2;
    chk("post_rst_state", 32'(state), 32'(ST_FETCH));
    chk("post_rst_imem_req", 32'(mem_if.imem_req), 32'd1);
    chk("post_rst_instret", instret, 32'd0);

    // add x3,x1,x2
    fetch(32'h0020_81B3, 0);
    exec_to_wb();
    wb_cycle(WB_ALU, PC_PLUS4);

    // lui x1 / jal x1,0 / jalr x1,0(x1)
    fetch(32'h0000_00B7, 0);
    exec_to_wb();
    wb_cycle(WB_UPPER, PC_PLUS4);
    fetch(32'h0000_00EF, 1);
    exec_to_wb();
    wb_cycle(WB_LINK, PC_BRANCH);
    fetch(32'h0000_80E7, 0);
    exec_to_wb();
    wb_cycle(WB_LINK, PC_JALR);

    // sb x2,2(x1) with three dmem wait states
    fetch(32'h0020_8123, 0);
    daddr_lo = 2'd2;
    #2;
    chk("sb_exec_dmem_req", 32'(mem_if.dmem_req), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_if.dmem_ready = (i == 3);
      #2;
      chk("sb_dmem_req", 32'(mem_if.dmem_req), 32'd1);
      chk("sb_we", 32'(mem_if.we), 32'h4);
      chk("sb_pc_we", 32'(pc_we), (i == 3) ? 32'd1 : 32'd0);
      chk("sb_wer", 32'(wer), 32'd0);
      tick();
    end
    mem_if.dmem_ready = 1'b0;
    exp_instret       = exp_instret + 32'd1;
    #2;
    chk("sb_instret", instret, exp_instret);
    chk("sb_state", 32'(state), 32'(ST_FETCH));

    // sw x2,0(x1) interrupted by reset in MEM, ready pulsed during reset
    fetch(32'h0020_A023, 0);
    daddr_lo = 2'd0;
    tick();
    #2;
    chk("sw_we", 32'(mem_if.we), 32'hF);
    tick();
    reset             = 1'b1;
    mem_if.dmem_ready = 1'b1;
    #2;
    chk("rstmem_dmem_req", 32'(mem_if.dmem_req), 32'd0);
    chk("rstmem_we", 32'(mem_if.we), 32'd0);
    chk("rstmem_pc_we", 32'(pc_we), 32'd0);
    chk("rstmem_instret", instret, 32'd0);
    chk("rstmem_state", 32'(state), 32'd0);
    tick();
    mem_if.dmem_ready = 1'b0;
    tick();
    reset = 1'b0;
    exp_instret = 32'd0;
    #2;
    chk("rstmem_after_state", 32'(state), 32'(ST_FETCH));
    chk("rstmem_after_imem_req", 32'(mem_if.imem_req), 32'd1);
    chk("rstmem_after_dmem_req", 32'(mem_if.dmem_req), 32'd0);
    chk("rstmem_after_instret", instret, 32'd0);

    // lw x3,0(x1), aligned, one imem wait
    fetch(32'h0000_A183, 1);
    daddr_lo = 2'd0;
    #2;
    chk("lw_exec_dmem_req", 32'(mem_if.dmem_req), 32'd0);
    tick();
    mem_if.dmem_ready = 1'b1;
    #2;
    chk("lw_mem_state", 32'(state), 32'(ST_MEM));
    chk("lw_we", 32'(mem_if.we), 32'd0);
    chk("lw_mem_pc_we", 32'(pc_we), 32'd0);
    tick();
    mem_if.dmem_ready = 1'b0;
    wb_cycle(WB_LOAD, PC_PLUS4);

    // beq taken, then not taken
    for (int t = 1; t >= 0; t--) begin
      fetch(32'h0020_8463, 0);
      br_taken = (t == 1);
      #2;
      chk("br_pc_we", 32'(pc_we), 32'd1);
      chk("br_pc_sel", 32'(pc_sel), (t == 1) ? 32'(PC_BRANCH) : 32'(PC_PLUS4));
      chk("br_wer", 32'(wer), 32'd0);
      tick();
      br_taken    = 1'b0;
      exp_instret = exp_instret + 32'd1;
      #2;
      chk("br_state", 32'(state), 32'(ST_FETCH));
      chk("br_instret", instret, exp_instret);
    end

    // misaligned lw -> TRAP, ready inputs ignored there
    fetch(32'h0000_A183, 0);
    daddr_lo = 2'd1;
    #2;
    chk("mis_exec_dmem_req", 32'(mem_if.dmem_req), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      mem_if.imem_ready = 1'b1;
      mem_if.dmem_ready = 1'b1;
      #2;
      chk("mis_state", 32'(state), 32'(ST_TRAP));
      chk("mis_illegal", 32'(illegal), 32'd1);
      chk("mis_dmem_req", 32'(mem_if.dmem_req), 32'd0);
      chk("mis_imem_req", 32'(mem_if.imem_req), 32'd0);
      chk("mis_ir_we", 32'(ir_we), 32'd0);
      chk("mis_pc_we", 32'(pc_we), 32'd0);
      chk("mis_instret", instret, exp_instret);
      tick();
    end
    mem_if.imem_ready = 1'b0;
    mem_if.dmem_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset       = 1'b0;
    exp_instret = 32'd0;
    daddr_lo    = 2'd0;
    #2;
    chk("trap_rst_illegal", 32'(illegal), 32'd0);
    chk("trap_rst_state", 32'(state), 32'(ST_FETCH));

    // add once so instret is nonzero, then illegal opcode
    fetch(32'h0020_81B3, 0);
    exec_to_wb();
    wb_cycle(WB_ALU, PC_PLUS4);
    fetch(32'h0000_007F, 0);
    for (int i = 0; i < 2; i++) begin
      #2;
      chk("ill_state", 32'(state), 32'(ST_TRAP));
      chk("ill_illegal", 32'(illegal), 32'd1);
      chk("ill_instret", instret, exp_instret);
      chk("ill_wer", 32'(wer), 32'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
